// File: rtl/wdt_rst_ctrl.sv
// Reset controller fed by the watchdog: stretches reset requests into a fixed
// active-low system reset, then a recovery window. Optional event counter: RST_CNT_EN.
module wdt_rst_ctrl #(
  parameter int HOLD_CYCLES    = 16,
  parameter int RECOVER_CYCLES = 8,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wdt_rst_sys,
  input  logic             wdt_rst_int,
  input  logic             sw_rst_req,
  input  logic             irq_ack,
  output logic             sys_rst_n,
  output logic             irq,
  output logic             wdt_reload,
  output logic             busy,
  output logic [1:0]       rst_cause,
  output logic [CNT_W-1:0] rst_count
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > RECOVER_CYCLES) ? HOLD_CYCLES : RECOVER_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] RCV_LAST  = CW'(RECOVER_CYCLES - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ASSERT  = 2'd1;
  localparam logic [1:0] ST_RECOVER = 2'd2;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_WDT = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;

  logic [1:0]    state;
  logic [CW-1:0] hold_cnt;
  logic [CW-1:0] rcv_cnt;
  logic          can_enter;
  logic          enter;

  // Requests are only honoured outside ASSERT; during ASSERT they are absorbed.
  assign can_enter = (state == ST_IDLE) || (state == ST_RECOVER);
  assign enter     = can_enter && (wdt_rst_sys || sw_rst_req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_ASSERT;
      hold_cnt   <= '0;
      rcv_cnt    <= '0;
      sys_rst_n  <= 1'b0;
      wdt_reload <= 1'b0;
      busy       <= 1'b1;
      rst_cause  <= CAUSE_POR;
    end else begin
      wdt_reload <= 1'b0;
      if (enter) begin
        state     <= ST_ASSERT;
        hold_cnt  <= '0;
        sys_rst_n <= 1'b0;
        busy      <= 1'b1;
        rst_cause <= wdt_rst_sys ? CAUSE_WDT : CAUSE_SW;
      end else begin
        case (state)
          ST_ASSERT: begin
            if (hold_cnt == HOLD_LAST) begin
              state      <= ST_RECOVER;
              rcv_cnt    <= '0;
              sys_rst_n  <= 1'b1;
              wdt_reload <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + CW'(1);
            end
          end
          ST_RECOVER: begin
            if (rcv_cnt == RCV_LAST) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              rcv_cnt <= rcv_cnt + CW'(1);
            end
          end
          ST_IDLE: begin
            busy <= 1'b0;
          end
          default: begin
            state     <= ST_ASSERT;
            hold_cnt  <= '0;
            sys_rst_n <= 1'b0;
            busy      <= 1'b1;
          end
        endcase
      end
    end
  end

  // Reset entry clears the warning; a fresh warning beats an acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else if (enter) begin
      irq <= 1'b0;
    end else if (can_enter && wdt_rst_int) begin
      irq <= 1'b1;
    end else if (irq_ack) begin
      irq <= 1'b0;
    end
  end

`ifdef RST_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_count <= '0;
    end else if (enter && wdt_rst_sys && (rst_count != {CNT_W{1'b1}})) begin
      rst_count <= rst_count + CNT_W'(1);
    end
  end
`else
  assign rst_count = '0;
`endif

endmodule

// File: tb/tb_wdt_rst_ctrl.sv
// Directed bench for wdt_rst_ctrl: POR, WDT/SW resets, irq handling,
// request absorption, re-entry from RECOVER, counter saturation, async reset.
module tb_wdt_rst_ctrl;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wdt_rst_sys = 1'b0;
  logic             wdt_rst_int = 1'b0;
  logic             sw_rst_req = 1'b0;
  logic             irq_ack = 1'b0;
  logic             sys_rst_n;
  logic             irq;
  logic             wdt_reload;
  logic             busy;
  logic [1:0]       rst_cause;
  logic [CNT_W-1:0] rst_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  int low_n, rel_n, busy_n;

  wdt_rst_ctrl #(.HOLD_CYCLES(16), .RECOVER_CYCLES(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .wdt_rst_sys(wdt_rst_sys), .wdt_rst_int(wdt_rst_int),
    .sw_rst_req(sw_rst_req), .irq_ack(irq_ack), .sys_rst_n(sys_rst_n), .irq(irq),
    .wdt_reload(wdt_reload), .busy(busy), .rst_cause(rst_cause), .rst_count(rst_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts low/reload/busy samples over n cycles starting with the current one.
  task automatic window(input int n, output int low, output int rel, output int bsy);
    low = 0; rel = 0; bsy = 0;
    for (int i = 0; i < n; i++) begin
      if (!sys_rst_n) low++;
      if (wdt_reload) rel++;
      if (busy) bsy++;
      tick();
    end
  endtask

  function automatic int cnt_inc(input int c);
`ifdef RST_CNT_EN
    return (c < 3) ? c + 1 : 3;
`else
    return c;
`endif
  endfunction

  task automatic pulse_wdt();
    wdt_rst_sys = 1'b1;
    tick();
    wdt_rst_sys = 1'b0;
    exp_cnt = cnt_inc(exp_cnt);
  endtask

  initial begin
    // 1: power-on reset
    repeat (3) tick();
    check("por_sys_rst_n", 32'(sys_rst_n), 0);
    check("por_busy", 32'(busy), 1);
    check("por_irq", 32'(irq), 0);
    check("por_reload", 32'(wdt_reload), 0);
    check("por_cause", 32'(rst_cause), 0);
    check("por_count", 32'(rst_count), 0);
    rst_n = 1'b1;
    window(30, low_n, rel_n, busy_n);
    check("por_low_cycles", low_n, 16);
    check("por_reload_pulses", rel_n, 1);
    check("por_busy_cycles", busy_n, 24);
    check("por_cause_after", 32'(rst_cause), 0);

    // 2: watchdog timeout from IDLE
    pulse_wdt();
    check("wdt_sys_rst_n", 32'(sys_rst_n), 0);
    check("wdt_cause", 32'(rst_cause), 1);
    check("wdt_count", 32'(rst_count), exp_cnt);
    window(30, low_n, rel_n, busy_n);
    check("wdt_low_cycles", low_n, 16);
    check("wdt_reload_pulses", rel_n, 1);
    check("wdt_busy_cycles", busy_n, 24);

    // 3: warning irq set / ack priority
    wdt_rst_int = 1'b1; tick(); wdt_rst_int = 1'b0;
    check("irq_set", 32'(irq), 1);
    wdt_rst_int = 1'b1; irq_ack = 1'b1; tick(); wdt_rst_int = 1'b0;
    check("irq_set_beats_ack", 32'(irq), 1);
    tick(); irq_ack = 1'b0;
    check("irq_ack_clear", 32'(irq), 0);

    // 4: absorbed request in ASSERT, SW re-entry from RECOVER
    pulse_wdt();
    repeat (5) tick();
    wdt_rst_sys = 1'b1; tick(); wdt_rst_sys = 1'b0;
    repeat (9) tick();
    check("absorb_still_low", 32'(sys_rst_n), 0);
    tick();
    check("absorb_release", 32'(sys_rst_n), 1);
    check("absorb_reload", 32'(wdt_reload), 1);
    check("absorb_count", 32'(rst_count), exp_cnt);
    repeat (3) tick();
    check("recover_busy", 32'(busy), 1);
    sw_rst_req = 1'b1; tick(); sw_rst_req = 1'b0;
    check("sw_reenter_low", 32'(sys_rst_n), 0);
    check("sw_cause", 32'(rst_cause), 2);
    check("sw_count_unchanged", 32'(rst_count), exp_cnt);
    window(30, low_n, rel_n, busy_n);
    check("sw_low_cycles", low_n, 16);
    check("sw_busy_cycles", busy_n, 24);

    // 5: simultaneous requests, irq cleared on entry
    wdt_rst_int = 1'b1; tick(); wdt_rst_int = 1'b0;
    check("irq_before_entry", 32'(irq), 1);
    wdt_rst_sys = 1'b1; sw_rst_req = 1'b1; wdt_rst_int = 1'b1;
    tick();
    wdt_rst_sys = 1'b0; sw_rst_req = 1'b0; wdt_rst_int = 1'b0;
    exp_cnt = cnt_inc(exp_cnt);
    check("both_cause_wdt", 32'(rst_cause), 1);
    check("entry_irq_clear", 32'(irq), 0);
    check("both_count", 32'(rst_count), exp_cnt);
    wdt_rst_int = 1'b1; tick(); wdt_rst_int = 1'b0;
    check("irq_ignored_assert", 32'(irq), 0);
    repeat (30) tick();

    // 6: counter saturation, then async reset mid-ASSERT
    for (int r = 0; r < 5; r++) begin
      pulse_wdt();
      check($sformatf("sat_count_%0d", r), 32'(rst_count), exp_cnt);
      repeat (30) tick();
    end
    pulse_wdt();
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("async_sys_rst_n", 32'(sys_rst_n), 0);
    check("async_busy", 32'(busy), 1);
    check("async_cause", 32'(rst_cause), 0);
    check("async_count", 32'(rst_count), 0);
    check("async_irq", 32'(irq), 0);
    check("async_reload", 32'(wdt_reload), 0);
    tick();
    rst_n = 1'b1;
    window(30, low_n, rel_n, busy_n);
    check("por2_low_cycles", low_n, 16);
    check("por2_busy_cycles", busy_n, 24);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
